// File: rtl/slot_reel_counter_if.sv
// Reel request/status bundle: the controller drives the start/stop requests,
// and the reel returns its digit and its spin status.
//
// Request semantics: i_start and i_stop are plain level requests with no
// acknowledge. The reel samples them on every rising clock edge and acts on
// them only in the state where they are meaningful: start in IDLE, stop in
// SPIN. In any other state a request is dropped, not queued, so a controller
// that wants an action must hold the level until o_spinning or o_done shows
// the effect. All reel outputs are registered.
interface slot_reel_counter_if;
  logic       i_start;
  logic       i_stop;
  logic [3:0] o_num;
  logic       o_spinning;
  logic       o_done;
  logic [1:0] dbg_state;

  modport master (
    output i_start,
    output i_stop,
    input  o_num,
    input  o_spinning,
    input  o_done,
    input  dbg_state
  );

  modport slave (
    input  i_start,
    input  i_stop,
    output o_num,
    output o_spinning,
    output o_done,
    output dbg_state
  );
endinterface

// File: rtl/slot_reel_counter.sv
// One slot-machine reel: a BCD digit that advances every DIV cycles while
// spinning. After a stop request it makes SLOW_STEPS further advances, each
// at twice the previous period, then returns to IDLE and pulses o_done.
module slot_reel_counter #(
  parameter int DIV        = 4,
  parameter int SLOW_STEPS = 3,
  parameter int CNT_W      = 16
) (
  input logic                i_clk,
  input logic                i_reset,
  slot_reel_counter_if.slave bus
);

  // The slow-step index has to reach SLOW_STEPS. Keep it at least one bit
  // wide so that SLOW_STEPS = 0 still elaborates.
  localparam int K_W = (SLOW_STEPS < 1) ? 1 : $clog2(SLOW_STEPS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SPIN = 2'd1,
    SLOW = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [3:0]       num_q, num_d;
  logic             spinning_q, spinning_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] spin_last;
  logic [CNT_W-1:0] slow_last;
  logic [3:0]       num_inc;
  logic [K_W-1:0]   k_inc;

  assign spin_last = CNT_W'(DIV - 1);
  // Slow step k lasts DIV << (k+1) cycles. k+1 never exceeds SLOW_STEPS while
  // in SLOW, so it fits in K_W bits.
  assign k_inc     = k_q + K_W'(1);
  assign slow_last = (CNT_W'(DIV) << k_inc) - CNT_W'(1);
  // Wrap 9 -> 0 so the digit can always be decoded as BCD.
  assign num_inc   = (num_q == 4'd9) ? 4'd0 : num_q + 4'd1;

  // Next-state, tick-counter and digit logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    num_d   = num_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          state_d = SPIN;
          cnt_d   = '0;
        end
      end
      SPIN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == spin_last) begin
          cnt_d = '0;
          num_d = num_inc;
        end
        // A tick that expires in the same cycle as the stop request still
        // advances the digit. The slow phase then starts from a clean count.
        if (bus.i_stop) begin
          cnt_d = '0;
          k_d   = '0;
          if (SLOW_STEPS == 0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = SLOW;
          end
        end
      end
      SLOW: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == slow_last) begin
          cnt_d = '0;
          num_d = num_inc;
          k_d   = k_inc;
          if (k_inc == K_W'(SLOW_STEPS)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        k_d     = '0;
      end
    endcase
    spinning_d = (state_d != IDLE);
  end

  // State and output registers; reset takes effect immediately.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      k_q        <= '0;
      num_q      <= 4'd0;
      spinning_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      num_q      <= num_d;
      spinning_q <= spinning_d;
      done_q     <= done_d;
    end
  end

  assign bus.o_num      = num_q;
  assign bus.o_spinning = spinning_q;
  assign bus.o_done     = done_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: doc/slot_reel_counter.md
Name: slot_reel_counter

Overview:
- One reel of the slot machine: a free-running decimal digit counter (0..9) that spins at a fixed rate after a start request.
- On a stop request it decelerates through a fixed number of progressively slower steps, then halts and flags completion.
- Its 4-bit digit output drives the display stage's 7-segment decimal decoder directly, so o_num is always a legal BCD digit (0..9).

Parameters:
- DIV, 4: clock cycles per digit advance while spinning at full speed; legal range is 1 or more.
- SLOW_STEPS, 3: number of digit advances performed after a stop request; legal range is 0 or more.
- CNT_W, 16: tick counter width; must hold (DIV << SLOW_STEPS) - 1.

Ports:
- i_clk, input, 1: system clock; all state changes on its rising edge.
- i_reset, input, 1: asynchronous, active-high reset.
- i_start, input, 1: level-sampled start request; acted on only in IDLE.
- i_stop, input, 1: level-sampled stop request; acted on only in SPIN.
- o_num, output, 4: current reel digit 0..9, registered; feeds the decimal decoder.
- o_spinning, output, 1: high while state is SPIN or SLOW, registered.
- o_done, output, 1: one-cycle pulse marking the final digit update of a spin.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE, o_num = 0, o_spinning = 0, o_done = 0, tick counter = 0, slow-step index k = 0.
  - Asserting reset mid-spin returns all of these to reset values immediately. No pending stop is remembered.
- States: IDLE, SPIN, SLOW.
- IDLE:
  - o_num holds its value; i_stop is ignored.
  - If i_start = 1: next state is SPIN and the tick counter clears to 0. o_spinning is 1 from the following cycle.
- SPIN:
  - The tick counter increments every cycle.
  - When the tick counter = DIV-1, the counter returns to 0 and o_num advances.
  - o_num advances as 0->1->...->9->0. It never takes a value above 9.
  - The first advance occurs DIV cycles after entering SPIN.
  - i_start is ignored.
  - If i_stop = 1:
    - Next state is SLOW with tick counter = 0 and k = 0.
    - If a tick expires in the same cycle, the advance still happens in that cycle.
    - If SLOW_STEPS = 0, next state is IDLE instead, and o_done pulses in that next cycle.
- SLOW:
  - Step k has period P_k = DIV << (k+1). With the defaults these periods are 8, 16 and 32 cycles.
  - When the tick counter = P_k - 1: o_num advances (with 9->0 wrap), the counter clears and k increments.
  - On the advance that brings k to SLOW_STEPS, next state is IDLE and o_done = 1 for exactly that cycle. The final o_num is visible in the same cycle.
  - i_start and i_stop are both ignored in SLOW.
- Final digit = (o_num value after the stop-acceptance edge + SLOW_STEPS) mod 10.
- o_done:
  - Driven high only on the SLOW->IDLE transition (or the SPIN->IDLE transition when SLOW_STEPS = 0); low at all other times.
  - An i_start present in the o_done cycle is accepted, because state is already IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan (DIV=4, SLOW_STEPS=3 unless stated):
1. Reset sequence:
   - Assert i_reset asynchronously mid-cycle -> o_num=0, o_spinning=0, o_done=0 before the next edge.
   - Then hold i_start=0 for 20 cycles -> outputs unchanged.
2. Spin and wrap:
   - Pulse i_start in IDLE -> o_spinning=1 the next cycle; o_num=1 after 4 cycles in SPIN.
   - o_num=9 after 36 cycles; o_num=0 after 40 cycles. o_num never exceeds 9.
3. Deceleration:
   - Assert i_stop one cycle while o_num=5 with no coincident tick.
   - -> o_num becomes 6, 7, 8 at 8, 16, 32 cycles after each preceding advance.
   - o_done pulses once with o_num=8; o_spinning=0 thereafter; o_num holds at 8 for 100 cycles.
4. Coincident stop/tick:
   - i_stop in the cycle the tick expires with o_num=9 -> o_num=0 at that edge, then 1, 2, 3.
   - Final o_num=3 with o_done.
5. Ignored requests:
   - i_start held high throughout SPIN and SLOW -> no restart and no period change.
   - i_stop in IDLE -> no effect.
   - i_start in the o_done cycle -> SPIN entered the next cycle.
6. Reset mid-SLOW and SLOW_STEPS=0:
   - i_reset during SLOW -> immediate IDLE with o_num=0 and no o_done.
   - With SLOW_STEPS=0, i_stop at o_num=4 -> o_done next cycle with o_num=4.
